duplicate_removal: RTL and testbench
====================================

DUPLICATE_REMOVAL -- requirements
Module: duplicate_removal

Interface
REQ-001 Parameter N, default 8: number of elements per input vector (N >= 2).
REQ-002 Parameter W, default 8: element width in bits.
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port in_valid, input, 1: arr is valid this cycle.
REQ-006 Port in_ready, output, 1: block can accept a new vector.
REQ-007 Port arr, input, W*N: packed input; element i = arr[W*(i+1)-1 -: W], element 0 in the LSBs.
REQ-008 Port out_valid, output, 1: out and unique_count hold a completed result.
REQ-009 Port out, output, W*N: packed unique elements, same packing as arr.
REQ-010 Port unique_count, output, $clog2(N+1) bits (4 for N=8): number of unique elements in out.

Function
REQ-011 FSM states: IDLE, SCAN, DONE; a transfer is accepted on the rising edge where in_valid && in_ready.
REQ-012 in_ready is high in IDLE and DONE and low in SCAN.
REQ-013 On accept: latch arr internally, clear the result buffer and count, set scan index to 0, enter SCAN, and drive out_valid low from the next cycle.
REQ-014 SCAN processes one element per cycle in index order 0..N-1. Each element is compared in parallel against all result slots below the current count. If there is no match, it is written to slot[count] and count increments.
REQ-015 After element N-1 is processed, the FSM enters DONE, and out_valid rises exactly N clock edges after the accepting edge.
REQ-016 Output order is first-occurrence order by input index. Equal values are removed wherever they appear, adjacent or not.
REQ-017 Slots at index >= unique_count shall read zero.
REQ-018 A value of zero is an ordinary element and is deduplicated like any other value.
REQ-019 While out_valid is high, out and unique_count are stable. They stay valid until the next accept.
REQ-020 An input accepted while in DONE starts a new scan immediately, with no idle cycle required.
REQ-021 in_valid during SCAN is ignored, and arr may change during SCAN without effect.
REQ-022 unique_count range is 1..N for any accepted vector. It never wraps: N unique elements gives count N.

Reset
REQ-023 When rst_n is low: state=IDLE, in_ready=1, out_valid=0, out=0, unique_count=0, and all internal buffers and the index are cleared. This takes effect asynchronously.
REQ-024 Reset asserted mid-SCAN aborts the operation, and no partial result is ever presented.

Configuration
REQ-025 Macro DUPLICATE_REMOVAL_DUP_COUNT_EN, when defined, adds output port dup_count, width $clog2(N+1), equal to N - unique_count. It is valid under out_valid and reset to 0.
REQ-026 When the macro is undefined, port dup_count and its logic are absent, and all other behaviour is identical.

Structure
REQ-027 Shared package dup_removal_pkg holds the FSM state enum and a function computing the count width ($clog2(N+1)).
REQ-028 One sub-module, dup_match, performs the parallel compare of one element against the N slots. It returns a hit flag when any slot below the count matches.

Verification
REQ-029 arr={10,10,20,20,30,40,40,50} (hex, MSB byte first), N=8 -> out_valid after 8 edges; unique_count=5; out bytes 0..4 = 50,40,30,20,10; bytes 5..7 = 0.
REQ-030 All elements 0xAA -> unique_count=1; out byte0=0xAA; the rest are 0.
REQ-031 Elements 0..7 = 01,02,...,08, all distinct -> unique_count=8; out equals arr; dup_count=0 when the macro is enabled.
REQ-032 Non-adjacent duplicates: byte0..7 = 05,00,05,07,00,07,09,05 -> unique_count=4; out bytes 0..3 = 05,00,07,09.
REQ-033 Reset pulse on the 4th SCAN cycle -> out_valid=0, out=0, unique_count=0, in_ready=1. A subsequent vector completes correctly.
REQ-034 Back-to-back: a new vector accepted in the same cycle out_valid first rises -> out_valid drops the next cycle. The second result appears N edges after its accept, and the first result is unchanged until then.

Source files
------------

// File: rtl/dup_removal_pkg.sv
// Shared types for the duplicate-removal block: FSM state encoding and count-width helper.
package dup_removal_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/dup_match.sv
// Parallel compare of one element against the result slots that are currently occupied.
module dup_match
    import dup_removal_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 8
) (
    input  logic [W-1:0]          elem,
    input  logic [W*N-1:0]        slots,
    input  logic [cnt_w(N)-1:0]   count,
    output logic                  hit
);

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < N; i++) begin
            if ((i < int'(count)) && (slots[W*i +: W] == elem)) begin
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/duplicate_removal.sv
// Removes repeated values from an N-element vector, one element per cycle, keeping first-occurrence order.
// Optional dup_count output is enabled by defining DUPLICATE_REMOVAL_DUP_COUNT_EN.
module duplicate_removal
    import dup_removal_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [W*N-1:0]        arr,
    output logic                  out_valid,
    output logic [W*N-1:0]        out,
    output logic [cnt_w(N)-1:0]   unique_count
`ifdef DUPLICATE_REMOVAL_DUP_COUNT_EN
    ,
    output logic [cnt_w(N)-1:0]   dup_count
`endif
);

    localparam int CW = cnt_w(N);
    localparam int IW = $clog2(N);

    state_t          state_q;
    state_t          state_d;
    logic [IW-1:0]   idx_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic [W*N-1:0]  arr_q;
    logic [W*N-1:0]  slots_q;
    logic [W*N-1:0]  slots_d;
    logic [W-1:0]    elem;
    logic            hit;
    logic            accept;
    logic            last;

    assign in_ready  = (state_q != SCAN);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid && in_ready;
    assign elem      = arr_q[W*idx_q +: W];
    assign last      = (idx_q == IW'(N - 1));

    dup_match #(
        .N (N),
        .W (W)
    ) u_match (
        .elem  (elem),
        .slots (slots_q),
        .count (count_q),
        .hit   (hit)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SCAN;
            SCAN:    if (last)   state_d = DONE;
            DONE:    if (accept) state_d = SCAN;
            default: state_d = IDLE;
        endcase
    end

    // A miss appends the element at the next free slot; unused slots stay zero from the accept clear.
    always_comb begin
        slots_d = slots_q;
        count_d = count_q;
        if (!hit) begin
            slots_d[W*int'(count_q) +: W] = elem;
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Published result only changes on the final scan edge, so it holds through a following scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arr_q        <= '0;
            slots_q      <= '0;
            count_q      <= '0;
            idx_q        <= '0;
            out          <= '0;
            unique_count <= '0;
        end else if (accept) begin
            arr_q   <= arr;
            slots_q <= '0;
            count_q <= '0;
            idx_q   <= '0;
        end else if (state_q == SCAN) begin
            slots_q <= slots_d;
            count_q <= count_d;
            idx_q   <= idx_q + IW'(1);
            if (last) begin
                out          <= slots_d;
                unique_count <= count_d;
            end
        end
    end

`ifdef DUPLICATE_REMOVAL_DUP_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dup_count <= '0;
        end else if (!accept && (state_q == SCAN) && last) begin
            dup_count <= CW'(N) - count_d;
        end
    end
`endif

endmodule

// File: tb/tb_duplicate_removal.sv
// Scoreboard bench for duplicate_removal: stimulus pushes expected results, a monitor pops on each new out_valid.
module tb_duplicate_removal;

    localparam int N  = 8;
    localparam int W  = 8;
    localparam int CW = 4;

    typedef struct {
        logic [W*N-1:0] out;
        logic [CW-1:0]  cnt;
        int             acc;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W*N-1:0] arr = '0;
    logic           out_valid;
    logic [W*N-1:0] out;
    logic [CW-1:0]  unique_count;
`ifdef DUPLICATE_REMOVAL_DUP_COUNT_EN
    logic [CW-1:0]  dup_count;
`endif

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    logic prev_valid = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    duplicate_removal #(
        .N (N),
        .W (W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .arr          (arr),
        .out_valid    (out_valid),
        .out          (out),
        .unique_count (unique_count)
`ifdef DUPLICATE_REMOVAL_DUP_COUNT_EN
        ,
        .dup_count    (dup_count)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every rising out_valid must match the oldest pending expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (out_valid && !prev_valid) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: got out=%h count=%0d expected no result", out, unique_count);
            end else begin
                e = sb.pop_front();
                check("out", out, e.out);
                check("unique_count", 64'(unique_count), 64'(e.cnt));
                check("latency", 64'(cyc - e.acc), 64'(N));
                check("in_ready_done", 64'(in_ready), 64'd1);
`ifdef DUPLICATE_REMOVAL_DUP_COUNT_EN
                check("dup_count", 64'(dup_count), 64'(N - int'(e.cnt)));
`endif
            end
        end
        prev_valid = out_valid;
    end

    // Called at a negedge; accept happens on the following posedge.
    task automatic send(input logic [63:0] a, input logic [63:0] eo, input logic [3:0] ec, input bit noise);
        exp_t e;
        check("in_ready_idle", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        arr      = a;
        @(negedge clk);
        e.out = eo;
        e.cnt = ec;
        e.acc = cyc;
        sb.push_back(e);
        check("in_ready_scan", 64'(in_ready), 64'd0);
        if (noise) begin
            arr = ~a;
            repeat (3) @(negedge clk);
        end
        in_valid = 1'b0;
        arr      = {$urandom, $urandom};
    endtask

    task automatic wait_result();
        int k = 0;
        while (!out_valid && k < 3 * N) begin
            @(negedge clk);
            k++;
        end
        if (!out_valid) begin
            tests++;
            fails++;
            $display("FAIL result_timeout: got out_valid=0 expected 1 within %0d cycles", 3 * N);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out", out, 64'd0);
        check("reset_count", 64'(unique_count), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        @(negedge clk);
        send(64'h1010202030404050, 64'h0000001020304050, 4'd5, 1'b1);
        wait_result();

        @(negedge clk);
        send(64'hAAAAAAAAAAAAAAAA, 64'h00000000000000AA, 4'd1, 1'b1);
        wait_result();

        @(negedge clk);
        send(64'h0807060504030201, 64'h0807060504030201, 4'd8, 1'b0);
        wait_result();

        @(negedge clk);
        send(64'h0509070007050005, 64'h0000000009070005, 4'd4, 1'b1);
        wait_result();

        @(negedge clk);
        send(64'h0000000000000000, 64'h0000000000000000, 4'd1, 1'b0);
        wait_result();

        @(negedge clk);
        send(64'h0101010101010102, 64'h0000000000000102, 4'd2, 1'b0);
        wait_result();

        // Back-to-back: second accept on the first out_valid cycle.
        @(negedge clk);
        send(64'h1010202030404050, 64'h0000001020304050, 4'd5, 1'b0);
        wait_result();
        send(64'h0509070007050005, 64'h0000000009070005, 4'd4, 1'b0);
        check("b2b_valid_drop", 64'(out_valid), 64'd0);
        repeat (N - 2) begin
            check("b2b_hold_out", out, 64'h0000001020304050);
            check("b2b_hold_count", 64'(unique_count), 64'd5);
            @(negedge clk);
        end
        wait_result();

        // Reset during the fourth scan cycle aborts with no result.
        @(negedge clk);
        in_valid = 1'b1;
        arr      = 64'h0807060504030201;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midscan_reset_out_valid", 64'(out_valid), 64'd0);
        check("midscan_reset_out", out, 64'd0);
        check("midscan_reset_count", 64'(unique_count), 64'd0);
        check("midscan_reset_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * N) @(negedge clk);

        send(64'h0807060504030201, 64'h0807060504030201, 4'd8, 1'b1);
        wait_result();

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
